wb_ram_slave: RTL and testbench



---
 rtl/wb_ram_slave.sv | 133 +++++++++++++
 tb/tb_wb_ram_slave.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_slave.sv
// Wishbone B4 pipelined slave in front of a word-addressed RAM.
// Fixed-latency ack/err response, with stall held while waiting.
module wb_ram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cyc,
  input  logic                    i_stb,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [DATA_WIDTH/8-1:0] i_sel,
  output logic                    o_stall,
  output logic                    o_ack,
  output logic                    o_err,
  output logic [DATA_WIDTH-1:0]   o_data
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic err_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic ack_d, err_d;
  logic [DATA_WIDTH-1:0] odata_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic accept, in_range;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH-1:0] rd_word, smp_word;

  assign accept   = i_cyc && i_stb && !o_stall;
  assign in_range = {1'b0, i_addr} < DEPTH_W;
  assign idx      = i_addr[IW-1:0];
  assign rd_word  = mem[idx];
  assign smp_word = (in_range && !i_we) ? rd_word : '0;

  // Writes commit at the accept edge so a following read sees them.
  always_ff @(posedge clk) begin
    if (accept && i_we && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (i_sel[b]) mem[idx][8*b +: 8] <= i_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      err_q  <= !in_range;
      data_q <= smp_word;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    odata_d = '0;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            ack_d   = in_range;
            err_d   = !in_range;
            odata_d = smp_word;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!i_cyc) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = '0;
          ack_d   = !err_q;
          err_d   = err_q;
          odata_d = data_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      o_stall <= 1'b0;
      o_ack   <= 1'b0;
      o_err   <= 1'b0;
      o_data  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_stall <= (state_d == S_WAIT);
      o_ack   <= ack_d;
      o_err   <= err_d;
      o_data  <= odata_d;
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: a zero-wait and a three-wait instance,
// checked each cycle against a transaction-level model.
module tb_wb_ram_slave;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] cyc, stb, we;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdat;
  logic [1:0][SW-1:0] sel;
  logic [1:0] stall, ack, err;
  logic [1:0][DW-1:0] rdat;

  wb_ram_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .DEPTH(DEPTH), .WAIT_STATES(0)
  ) u0 (
    .clk(clk), .rst(rst),
    .i_cyc(cyc[0]), .i_stb(stb[0]), .i_we(we[0]),
    .i_addr(addr[0]), .i_data(wdat[0]), .i_sel(sel[0]),
    .o_stall(stall[0]), .o_ack(ack[0]),
    .o_err(err[0]), .o_data(rdat[0])
  );

  wb_ram_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .DEPTH(DEPTH), .WAIT_STATES(3)
  ) u1 (
    .clk(clk), .rst(rst),
    .i_cyc(cyc[1]), .i_stb(stb[1]), .i_we(we[1]),
    .i_addr(addr[1]), .i_data(wdat[1]), .i_sel(sel[1]),
    .o_stall(stall[1]), .o_ack(ack[1]),
    .o_err(err[1]), .o_data(rdat[1])
  );

  int checks = 0;
  int failures = 0;

  // Model state: memory image and the outstanding response per instance
  logic [DW-1:0] mmem [2][DEPTH];
  bit e_stall [2];
  bit e_ack [2];
  bit e_err [2];
  logic [DW-1:0] e_data [2];
  bit pend [2];
  int rem [2];
  bit p_err [2];
  logic [DW-1:0] p_data [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      e_stall[d] = 0; e_ack[d] = 0; e_err[d] = 0;
      e_data[d] = '0; pend[d] = 0; rem[d] = 0;
      p_err[d] = 0; p_data[d] = '0;
    end
  end

  function automatic int wsof(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(string nm, int d, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h",
               nm, d, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    for (int d = 0; d < 2; d++) begin
      bit acc, oob, r_ack, r_err;
      logic [DW-1:0] r_data, word;
      int a;
      if (rst) begin
        pend[d] = 0; rem[d] = 0;
        e_stall[d] = 0; e_ack[d] = 0;
        e_err[d] = 0; e_data[d] = '0;
      end else begin
        acc = cyc[d] && stb[d] && !e_stall[d];
        r_ack = 0; r_err = 0; r_data = '0;
        if (pend[d]) begin
          if (!cyc[d]) pend[d] = 0;
          else begin
            rem[d] = rem[d] - 1;
            if (rem[d] == 0) begin
              r_ack = !p_err[d];
              r_err = p_err[d];
              r_data = p_data[d];
              pend[d] = 0;
            end
          end
        end
        if (acc) begin
          a = int'(addr[d]);
          oob = (a >= DEPTH);
          word = '0;
          if (!oob && we[d]) begin
            word = mmem[d][a];
            for (int b = 0; b < SW; b++)
              if (sel[d][b]) word[8*b +: 8] = wdat[d][8*b +: 8];
            mmem[d][a] = word;
            word = '0;
          end else if (!oob) begin
            word = mmem[d][a];
          end
          if (wsof(d) == 0) begin
            r_ack = !oob; r_err = oob; r_data = word;
          end else begin
            pend[d] = 1; rem[d] = wsof(d);
            p_err[d] = oob; p_data[d] = word;
          end
        end
        e_ack[d] = r_ack;
        e_err[d] = r_err;
        e_data[d] = r_data;
        e_stall[d] = pend[d];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("m_stall", d, stall[d], e_stall[d]);
      chk("m_ack", d, ack[d], e_ack[d]);
      chk("m_err", d, err[d], e_err[d]);
      chk("m_data", d, rdat[d], e_data[d]);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(int d, bit c, bit s, bit w, int a,
                       logic [31:0] dat, logic [3:0] sl);
    cyc[d] = c; stb[d] = s; we[d] = w;
    addr[d] = AW'(a); wdat[d] = dat; sel[d] = sl;
  endtask

  task automatic idle(int d);
    drive(d, 0, 0, 0, 0, 32'h0, 4'h0);
  endtask

  // One request on the wait-state instance, held open until its ack
  task automatic w3(int a, bit w, logic [31:0] dat, string nm,
                    logic [31:0] expd);
    tick; drive(1, 1, 1, w, a, dat, 4'hF);
    tick; drive(1, 1, 0, 0, 0, 32'h0, 4'h0);
    repeat (3) tick;
    chk({nm, "_ack"}, 1, ack[1], 1);
    if (!w) chk({nm, "_data"}, 1, rdat[1], expd);
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    idle(0); idle(1);
    repeat (2) tick;
    for (int d = 0; d < 2; d++) begin
      chk("rst_stall", d, stall[d], 0);
      chk("rst_ack", d, ack[d], 0);
      chk("rst_err", d, err[d], 0);
      chk("rst_data", d, rdat[d], 0);
    end
    rst = 1'b0;
    tick;

    tick; drive(0, 1, 1, 1, 5, 32'hDEADBEEF, 4'hF);
    tick; chk("t1_ack_w", 0, ack[0], 1);
    chk("t1_stall", 0, stall[0], 0);
    drive(0, 1, 1, 0, 5, 32'h0, 4'hF);
    tick; chk("t1_ack_r", 0, ack[0], 1);
    chk("t1_data", 0, rdat[0], 32'hDEADBEEF);
    idle(0);

    tick; drive(0, 1, 1, 1, 7, 32'h11223344, 4'hF);
    tick; drive(0, 1, 1, 1, 7, 32'hAABBCCDD, 4'b0101);
    tick; drive(0, 1, 1, 0, 7, 32'h0, 4'h0);
    tick; chk("t2_data", 0, rdat[0], 32'h11BB33DD);
    idle(0);

    tick; drive(0, 1, 1, 1, 44, 32'h44444444, 4'hF);
    tick; drive(0, 1, 1, 1, 300, 32'hFFFFFFFF, 4'hF);
    tick; chk("t4_err_w", 0, err[0], 1);
    chk("t4_ack_w", 0, ack[0], 0);
    drive(0, 1, 1, 0, 300, 32'h0, 4'hF);
    tick; chk("t4_err_r", 0, err[0], 1);
    chk("t4_ack_r", 0, ack[0], 0);
    chk("t4_data_r", 0, rdat[0], 0);
    drive(0, 1, 1, 0, 44, 32'h0, 4'hF);
    tick; chk("t4_ack44", 0, ack[0], 1);
    chk("t4_data44", 0, rdat[0], 32'h44444444);
    idle(0);

    w3(5, 1, 32'hCAFEF00D, "t3_w", 32'h0);
    tick; drive(1, 1, 1, 0, 5, 32'h0, 4'hF);
    tick; chk("t3_st1", 1, stall[1], 1);
    drive(1, 1, 1, 1, 6, 32'h66666666, 4'hF);
    tick; chk("t3_st2", 1, stall[1], 1);
    tick; chk("t3_st3", 1, stall[1], 1);
    chk("t3_noack", 1, ack[1], 0);
    tick; chk("t3_ack", 1, ack[1], 1);
    chk("t3_st4", 1, stall[1], 0);
    chk("t3_data", 1, rdat[1], 32'hCAFEF00D);
    tick; chk("t3_held", 1, stall[1], 1);
    drive(1, 1, 0, 0, 0, 32'h0, 4'h0);
    repeat (3) tick;
    chk("t3_ack2", 1, ack[1], 1);
    idle(1);
    w3(6, 0, 32'h0, "t3_r6", 32'h66666666);

    tick; drive(1, 1, 1, 1, 9, 32'h5A5A5A5A, 4'hF);
    tick; drive(1, 1, 0, 0, 0, 32'h0, 4'h0);
    tick; idle(1);
    tick; chk("t5_idle", 1, stall[1], 0);
    chk("t5_noack", 1, ack[1], 0);
    repeat (4) tick;
    w3(9, 0, 32'h0, "t5_r", 32'h5A5A5A5A);

    w3(12, 1, 32'h12345678, "t6_w", 32'h0);
    tick; drive(1, 1, 1, 0, 12, 32'h0, 4'hF);
    tick; chk("t6_wait", 1, stall[1], 1);
    drive(1, 1, 0, 0, 0, 32'h0, 4'h0);
    #2 rst = 1'b1;
    #1;
    chk("t6_stall", 1, stall[1], 0);
    chk("t6_ack", 1, ack[1], 0);
    chk("t6_err", 1, err[1], 0);
    chk("t6_data", 1, rdat[1], 0);
    idle(0); idle(1);
    repeat (2) tick;
    rst = 1'b0;
    repeat (5) tick;
    w3(12, 0, 32'h0, "t6_r", 32'h12345678);
    tick; drive(0, 1, 1, 0, 7, 32'h0, 4'h0);
    tick; chk("t6_d0", 0, rdat[0], 32'h11BB33DD);
    idle(0);
    repeat (2) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
